ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_pkg.sv | 6 +
 rtl/fifo_ptr.sv | 16 +
 rtl/ram_fifo_ctrl.sv | 67 ++++++
 tb/tb_ram_fifo_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: default geometry shared by ram, ram_fifo_ctrl and their benches
package ram_pkg;
   localparam int RAM_WIDTH  = 8;
   localparam int RAM_DEPTH  = 512;
   localparam int ADDR_WIDTH = 9;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping address incrementer with synchronous active-low clear
module fifo_ptr #(
   parameter int DEPTH = ram_pkg::RAM_DEPTH,
   parameter int AW    = ram_pkg::ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [AW-1:0] ptr
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   // advance on inc, wrapping at DEPTH-1 so non-power-of-two depths work
   always_ff @(posedge clk)
      if (!rst_n) ptr <= '0;
      else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller owning the ports of an external dual-port ram
module ram_fifo_ctrl #(
   parameter int RAM_WIDTH     = ram_pkg::RAM_WIDTH,
   parameter int RAM_DEPTH     = ram_pkg::RAM_DEPTH,
   parameter int ADDR_WIDTH    = ram_pkg::ADDR_WIDTH,
   parameter int AFULL_THRESH  = RAM_DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [RAM_WIDTH-1:0]  push_data,
   input  logic                  pop,
   output logic [RAM_WIDTH-1:0]  pop_data,
   output logic                  pop_vld,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_wr_en,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [RAM_WIDTH-1:0]  ram_wr_data,
   input  logic [RAM_WIDTH-1:0]  ram_rd_data
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] FULL_C = CW'(RAM_DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_THRESH);
   logic push_ok, pop_ok;
   assign full         = count == FULL_C;
   assign empty        = count == '0;
   assign almost_full  = count >= AF_C;
   assign almost_empty = count <= AE_C;
   assign push_ok      = push & ~full;
   assign pop_ok       = pop & ~empty;
   assign ram_wr_en    = push_ok & rst_n;
   assign ram_rd_en    = pop_ok & rst_n;
   assign ram_wr_data  = push_data;
   assign pop_data     = ram_rd_data;
   fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)) u_wr_ptr (
      .clk(clk), .rst_n(rst_n), .inc(push_ok), .ptr(ram_wr_addr)
   );
   fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)) u_rd_ptr (
      .clk(clk), .rst_n(rst_n), .inc(pop_ok), .ptr(ram_rd_addr)
   );
   // occupancy: simultaneous accepted push and pop leave count unchanged
   always_ff @(posedge clk)
      if (!rst_n) count <= '0;
      else if (push_ok & ~pop_ok) count <= count + 1'b1;
      else if (pop_ok & ~push_ok) count <= count - 1'b1;
   // read-valid tracks the ram's one-cycle read latency; error flags are sticky
   always_ff @(posedge clk)
      if (!rst_n) begin
         pop_vld   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_vld   <= pop_ok;
         overflow  <= overflow | (push & full);
         underflow <= underflow | (pop & empty);
      end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed self-checking bench with a behavioural one-cycle-read ram
module tb_ram_fifo_ctrl;
   logic       clk = 0, rst_n = 0, push = 0, pop = 0;
   logic [7:0] push_data = 0, pop_data, ram_wr_data, ram_rd_data;
   logic       pop_vld, full, empty, almost_full, almost_empty, overflow, underflow;
   logic       ram_wr_en, ram_rd_en;
   logic [8:0] ram_wr_addr, ram_rd_addr;
   logic [9:0] count;
   logic [7:0] mem [512];
   int n_cmp = 0, n_err = 0;

   ram_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_vld(pop_vld), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .ram_wr_en(ram_wr_en),
      .ram_rd_en(ram_rd_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      push = 0; pop = 0; rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic fill512();
      for (int i = 0; i < 512; i++) begin
         push = 1; push_data = 8'(i);
         tick();
      end
      push = 0;
   endtask

   task automatic test_reset();
      push = 1; pop = 1; rst_n = 0; #1;
      n_cmp++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got %b exp 0", ram_wr_en); end
      n_cmp++; if (ram_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en got %b exp 0", ram_rd_en); end
      tick();
      push = 0; pop = 0; rst_n = 1; #1;
      n_cmp++; if (count !== 10'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
      n_cmp++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin n_err++; $display("FAIL rst_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); end
      n_cmp++; if ({pop_vld, overflow, underflow} !== 3'b000) begin n_err++; $display("FAIL rst_vld_err got %b exp 000", {pop_vld, overflow, underflow}); end
      tick();
   endtask

   task automatic test_single();
      do_reset();
      push = 1; push_data = 8'h06; #1;
      n_cmp++; if ({ram_wr_en, ram_wr_addr} !== {1'b1, 9'd0}) begin n_err++; $display("FAIL single_wr got en=%b addr=%0d exp en=1 addr=0", ram_wr_en, ram_wr_addr); end
      tick();
      push = 0; #1;
      n_cmp++; if ({empty, count} !== {1'b0, 10'd1}) begin n_err++; $display("FAIL single_after_push got empty=%b count=%0d exp 0/1", empty, count); end
      pop = 1; #1;
      n_cmp++; if ({ram_rd_en, ram_rd_addr} !== {1'b1, 9'd0}) begin n_err++; $display("FAIL single_rd got en=%b addr=%0d exp en=1 addr=0", ram_rd_en, ram_rd_addr); end
      tick();
      pop = 0; #1;
      n_cmp++; if ({pop_vld, pop_data} !== {1'b1, 8'h06}) begin n_err++; $display("FAIL single_pop got vld=%b data=%h exp 1/06", pop_vld, pop_data); end
      n_cmp++; if ({empty, count} !== {1'b1, 10'd0}) begin n_err++; $display("FAIL single_after_pop got empty=%b count=%0d exp 1/0", empty, count); end
      tick();
      n_cmp++; if (pop_vld !== 1'b0) begin n_err++; $display("FAIL single_vld_drop got %b exp 0", pop_vld); end
   endtask

   task automatic test_overflow();
      do_reset();
      fill512();
      n_cmp++; if ({full, almost_full, count} !== {1'b1, 1'b1, 10'd512}) begin n_err++; $display("FAIL fill got full=%b af=%b count=%0d exp 1/1/512", full, almost_full, count); end
      push = 1; push_data = 8'hEE; #1;
      n_cmp++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_wr_en got %b exp 0", ram_wr_en); end
      tick();
      push = 0; #1;
      n_cmp++; if ({overflow, count} !== {1'b1, 10'd512}) begin n_err++; $display("FAIL ovf got ovf=%b count=%0d exp 1/512", overflow, count); end
      n_cmp++; if (mem[0] !== 8'h00) begin n_err++; $display("FAIL ovf_mem0 got %h exp 00", mem[0]); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      fill512();
      push = 1; pop = 1; push_data = 8'hAB; #1;
      n_cmp++; if ({ram_wr_en, ram_rd_en} !== 2'b01) begin n_err++; $display("FAIL fullpp_en got wr=%b rd=%b exp 0/1", ram_wr_en, ram_rd_en); end
      tick();
      push = 0; pop = 0; #1;
      n_cmp++; if ({overflow, full, count} !== {1'b1, 1'b0, 10'd511}) begin n_err++; $display("FAIL fullpp got ovf=%b full=%b count=%0d exp 1/0/511", overflow, full, count); end
      n_cmp++; if ({pop_vld, pop_data} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL fullpp_data got vld=%b data=%h exp 1/00", pop_vld, pop_data); end
   endtask

   task automatic test_underflow();
      do_reset();
      push = 1; pop = 1; push_data = 8'h5A; #1;
      n_cmp++; if ({ram_wr_en, ram_rd_en} !== 2'b10) begin n_err++; $display("FAIL unf_en got wr=%b rd=%b exp 1/0", ram_wr_en, ram_rd_en); end
      tick();
      push = 0; pop = 0; #1;
      n_cmp++; if ({underflow, overflow, pop_vld, count} !== {3'b100, 10'd1}) begin n_err++; $display("FAIL unf got unf=%b ovf=%b vld=%b count=%0d exp 1/0/0/1", underflow, overflow, pop_vld, count); end
      tick();
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_sticky got %b exp 1", underflow); end
   endtask

   task automatic test_wrap();
      int wp = 0, rp = 0, cnt = 0, nw = 0, nr = 0;
      logic       exp_vld = 0;
      logic [7:0] exp_data = 0, q[$];
      do_reset();
      for (int c = 0; c < 1110; c++) begin
         push = (c < 600); pop = (c >= 510); push_data = 8'(nw * 7 + 3); #1;
         if (push) begin
            n_cmp++; if (ram_wr_addr !== 9'(wp)) begin n_err++; $display("FAIL wrap_wr_addr c=%0d got %0d exp %0d", c, ram_wr_addr, wp); end
         end
         if (pop) begin
            n_cmp++; if (ram_rd_addr !== 9'(rp)) begin n_err++; $display("FAIL wrap_rd_addr c=%0d got %0d exp %0d", c, ram_rd_addr, rp); end
         end
         if (pop) begin exp_data = q.pop_front(); rp = (rp == 511) ? 0 : rp + 1; nr++; end
         if (push) begin q.push_back(push_data); wp = (wp == 511) ? 0 : wp + 1; nw++; end
         exp_vld = pop;
         cnt = cnt + int'(push) - int'(pop);
         tick(); #1;
         n_cmp++; if (count !== 10'(cnt)) begin n_err++; $display("FAIL wrap_count c=%0d got %0d exp %0d", c, count, cnt); end
         n_cmp++; if (almost_full !== (cnt >= 508)) begin n_err++; $display("FAIL wrap_afull c=%0d cnt=%0d got %b", c, cnt, almost_full); end
         n_cmp++; if (almost_empty !== (cnt <= 4)) begin n_err++; $display("FAIL wrap_aempty c=%0d cnt=%0d got %b", c, cnt, almost_empty); end
         n_cmp++; if (pop_vld !== exp_vld) begin n_err++; $display("FAIL wrap_vld c=%0d got %b exp %b", c, pop_vld, exp_vld); end
         if (exp_vld) begin
            n_cmp++; if (pop_data !== exp_data) begin n_err++; $display("FAIL wrap_data c=%0d got %h exp %h", c, pop_data, exp_data); end
         end
      end
      push = 0; pop = 0;
      n_cmp++; if ({empty, ram_wr_addr, ram_rd_addr} !== {1'b1, 9'd88, 9'd88}) begin n_err++; $display("FAIL wrap_end got empty=%b wp=%0d rp=%0d exp 1/88/88", empty, ram_wr_addr, ram_rd_addr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pop = 1; tick(); pop = 0;
      for (int i = 0; i < 10; i++) begin push = 1; push_data = 8'(i + 16); tick(); end
      push = 0; #1;
      n_cmp++; if ({underflow, count} !== {1'b1, 10'd10}) begin n_err++; $display("FAIL mid_pre got unf=%b count=%0d exp 1/10", underflow, count); end
      pop = 1; rst_n = 0; #1;
      n_cmp++; if (ram_rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_en got %b exp 0", ram_rd_en); end
      tick();
      pop = 0; rst_n = 1; #1;
      n_cmp++; if ({count, empty, pop_vld, overflow, underflow} !== {10'd0, 4'b1000}) begin n_err++; $display("FAIL mid_post got count=%0d empty=%b vld=%b ovf=%b unf=%b exp 0/1/0/0/0", count, empty, pop_vld, overflow, underflow); end
      n_cmp++; if ({ram_wr_addr, ram_rd_addr} !== 18'd0) begin n_err++; $display("FAIL mid_ptrs got wp=%0d rp=%0d exp 0/0", ram_wr_addr, ram_rd_addr); end
   endtask

   initial begin
      tick();
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_underflow();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
